// File: rtl/alu_issue.sv
// Issues one decoded RV32I OP/OP-IMM/LUI instruction to an external ALU over en/valid
// and holds the result (or a timeout error) for writeback; SLT/SLTU are resolved locally.
module alu_issue #(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [2:0]           funct3_i,
  input  logic                 funct7_b5_i,
  input  logic                 is_imm_i,
  input  logic                 is_lui_i,
  input  logic [WIDTH-1:0]     rs1_data_i,
  input  logic [WIDTH-1:0]     rs2_data_i,
  input  logic [WIDTH-1:0]     imm_i,
  output logic                 alu_en_o,
  output logic [WIDTH-28:0]    alu_op_o,
  output logic [WIDTH-1:0]     alu_a_o,
  output logic [WIDTH-1:0]     alu_b_o,
  input  logic                 alu_valid_i,
  input  logic [WIDTH-1:0]     alu_result_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [WIDTH-1:0]     out_data_o,
  output logic                 out_err_o
);

  localparam int OPW = WIDTH - 27;
  localparam int CW  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t             state_q;
  logic               alu_en_q;
  logic [OPW-1:0]     alu_op_q;
  logic [WIDTH-1:0]   alu_a_q;
  logic [WIDTH-1:0]   alu_b_q;
  logic               out_valid_q;
  logic               out_err_q;
  logic [WIDTH-1:0]   out_data_q;
  logic [CW-1:0]      cnt_q;

  logic [WIDTH-1:0]   opnd_b;
  logic [OPW-1:0]     alu_op_d;
  logic [WIDTH-1:0]   alu_b_d;
  logic               is_slt;
  logic               is_shift;
  logic               lt_d;

  always_comb begin
    opnd_b   = is_imm_i ? imm_i : rs2_data_i;
    is_slt   = !is_lui_i && (funct3_i == 3'b010 || funct3_i == 3'b011);
    is_shift = !is_lui_i && (funct3_i == 3'b001 || funct3_i == 3'b101);
    lt_d     = funct3_i[0] ? (rs1_data_i < opnd_b)
                           : ($signed(rs1_data_i) < $signed(opnd_b));
    alu_op_d = OPW'(5'b00001);
    if (is_lui_i) begin
      alu_op_d = OPW'(5'b11000);
    end else begin
      case (funct3_i)
        3'b000:  alu_op_d = (!is_imm_i && funct7_b5_i) ? OPW'(5'b00011) : OPW'(5'b00001);
        3'b001:  alu_op_d = OPW'(5'b01110);
        3'b100:  alu_op_d = OPW'(5'b01101);
        3'b101:  alu_op_d = funct7_b5_i ? OPW'(5'b10000) : OPW'(5'b01111);
        3'b110:  alu_op_d = OPW'(5'b01100);
        3'b111:  alu_op_d = OPW'(5'b01010);
        default: alu_op_d = OPW'(5'b00001);
      endcase
    end
    // Shift amount is only the low five bits; upper immediate bits carry funct7.
    alu_b_d = is_shift ? {{(WIDTH-5){1'b0}}, opnd_b[4:0]} : opnd_b;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      alu_en_q    <= 1'b0;
      alu_op_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
      out_data_q  <= '0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid_i) begin
            if (is_slt) begin
              out_data_q  <= {{(WIDTH-1){1'b0}}, lt_d};
              out_err_q   <= 1'b0;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              alu_op_q <= alu_op_d;
              alu_a_q  <= rs1_data_i;
              alu_b_q  <= alu_b_d;
              alu_en_q <= 1'b1;
              state_q  <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          alu_en_q <= 1'b0;
          cnt_q    <= '0;
          state_q  <= S_WAIT;
        end
        S_WAIT: begin
          if (alu_valid_i) begin
            out_data_q  <= alu_result_i;
            out_err_q   <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else if (cnt_q == CNT_LAST) begin
            out_data_q  <= '0;
            out_err_q   <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DONE: begin
          if (out_ready_i) begin
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
            cnt_q       <= '0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready_o  = rst_ni && (state_q == S_IDLE);
  assign alu_en_o    = alu_en_q;
  assign alu_op_o    = alu_op_q;
  assign alu_a_o     = alu_a_q;
  assign alu_b_o     = alu_b_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_err_o   = out_err_q;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed instructions, a simple responding ALU, scoreboard-checked results.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  funct3;
  logic        funct7_b5;
  logic        is_imm;
  logic        is_lui;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] imm;
  logic        alu_en;
  logic [4:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic        alu_valid = 1'b0;
  logic [31:0] alu_result = 32'h0;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_err;

  logic mute  = 1'b0;
  logic stray = 1'b0;
  int   cyc   = 0;
  int   errors = 0;
  int   checks = 0;

  typedef struct {
    logic [31:0] d;
    logic        e;
    int          lat;
    int          hs;
  } exp_t;
  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } alu_exp_t;

  exp_t     sb_q[$];
  alu_exp_t alu_q[$];

  alu_issue #(.WIDTH(32), .TIMEOUT_CYCLES(15)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .funct3_i(funct3), .funct7_b5_i(funct7_b5), .is_imm_i(is_imm), .is_lui_i(is_lui),
    .rs1_data_i(rs1_data), .rs2_data_i(rs2_data), .imm_i(imm),
    .alu_en_o(alu_en), .alu_op_o(alu_op), .alu_a_o(alu_a), .alu_b_o(alu_b),
    .alu_valid_i(alu_valid), .alu_result_i(alu_result),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .out_err_o(out_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] alu_f(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      5'd1:    return a + b;
      5'd3:    return a - b;
      5'd14:   return a << b[4:0];
      5'd15:   return a >> b[4:0];
      5'd16:   return $signed(a) >>> b[4:0];
      5'd13:   return a ^ b;
      5'd12:   return a | b;
      5'd10:   return a & b;
      5'd24:   return b;
      default: return 32'h0;
    endcase
  endfunction

  // Responder ALU: valid one cycle after en unless muted; 'stray' injects an unsolicited valid.
  always @(posedge clk) begin
    alu_valid  <= (alu_en && !mute) || stray;
    alu_result <= stray ? 32'hDEAD_BEEF : alu_f(alu_op, alu_a, alu_b);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  logic        prev_vld = 1'b0;
  logic        prev_en  = 1'b0;
  logic [31:0] held_d;
  logic        held_e;
  int          first_cyc;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_vld = 1'b0;
      prev_en  = 1'b0;
    end else begin
      if (alu_en) begin
        chk("alu_en_single_pulse", {31'b0, prev_en}, 32'h0);
        if (alu_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_alu_en: op %h a %h b %h (t=%0t)", alu_op, alu_a, alu_b, $time);
        end else begin
          alu_exp_t x;
          x = alu_q.pop_front();
          chk("alu_op", {27'b0, alu_op}, {27'b0, x.op});
          chk("alu_a", alu_a, x.a);
          chk("alu_b", alu_b, x.b);
        end
      end
      prev_en = alu_en;
      if (out_valid) begin
        chk("in_ready_low_in_done", {31'b0, in_ready}, 32'h0);
        if (!prev_vld) begin
          first_cyc = cyc;
          held_d    = out_data;
          held_e    = out_err;
        end else begin
          chk("out_data_stable", out_data, held_d);
          chk("out_err_stable", {31'b0, out_err}, {31'b0, held_e});
        end
        if (out_ready) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out_valid: data %h err %b (t=%0t)", out_data, out_err, $time);
          end else begin
            exp_t e;
            e = sb_q.pop_front();
            chk("out_data", out_data, e.d);
            chk("out_err", {31'b0, out_err}, {31'b0, e.e});
            chk("latency", first_cyc - e.hs + 1, e.lat);
          end
        end
      end
      prev_vld = out_valid;
    end
  end

  task automatic send(input logic [2:0] f3, input logic b5, input logic imi, input logic lui,
                      input logic [31:0] a, input logic [31:0] b2, input logic [31:0] im,
                      input logic [4:0] eop, input logic [31:0] eb, input logic use_alu,
                      input logic [31:0] ed, input logic ee, input int elat, input logic track);
    int n;
    exp_t     e;
    alu_exp_t x;
    funct3 = f3; funct7_b5 = b5; is_imm = imi; is_lui = lui;
    rs1_data = a; rs2_data = b2; imm = im;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: in_ready stuck %b", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (use_alu) begin
      x.op = eop; x.a = a; x.b = eb;
      alu_q.push_back(x);
    end
    if (track) begin
      e.d = ed; e.e = ee; e.lat = elat; e.hs = cyc;
      sb_q.push_back(e);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb_q.size() != 0 || !in_ready) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: pending %0d in_ready %b", sb_q.size(), in_ready);
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    funct3 = 3'b0; funct7_b5 = 1'b0; is_imm = 1'b0; is_lui = 1'b0;
    rs1_data = 32'h0; rs2_data = 32'h0; imm = 32'h0;
    #3;
    chk("rst_in_ready", {31'b0, in_ready}, 32'h0);
    chk("rst_alu_en", {31'b0, alu_en}, 32'h0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_out_err", {31'b0, out_err}, 32'h0);
    chk("rst_alu_op", {27'b0, alu_op}, 32'h0);
    chk("rst_alu_a", alu_a, 32'h0);
    chk("rst_alu_b", alu_b, 32'h0);
    chk("rst_out_data", out_data, 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("idle_in_ready", {31'b0, in_ready}, 32'h1);

    //   f3     b5    imm   lui   rs1           rs2           imm           op      alu_b         alu  data          err  lat  trk
    send(3'b000, 1'b0, 1'b0, 1'b0, 32'd5,        32'd7,        32'h0,        5'b00001, 32'd7,       1'b1, 32'd12,       1'b0, 3, 1'b1);
    send(3'b000, 1'b1, 1'b0, 1'b0, 32'd3,        32'd5,        32'h0,        5'b00011, 32'd5,       1'b1, 32'hFFFF_FFFE, 1'b0, 3, 1'b1);
    send(3'b000, 1'b1, 1'b1, 1'b0, 32'd10,       32'd99,       32'hFFFF_FFFF, 5'b00001, 32'hFFFF_FFFF, 1'b1, 32'd9,     1'b0, 3, 1'b1);
    send(3'b101, 1'b1, 1'b1, 1'b0, 32'h8000_0000, 32'h0,       32'h0000_0404, 5'b10000, 32'h4,       1'b1, 32'hF800_0000, 1'b0, 3, 1'b1);
    send(3'b001, 1'b0, 1'b1, 1'b1, 32'h0,        32'h0,        32'h1234_5000, 5'b11000, 32'h1234_5000, 1'b1, 32'h1234_5000, 1'b0, 3, 1'b1);
    send(3'b001, 1'b0, 1'b0, 1'b0, 32'h1,        32'h23,       32'h0,        5'b01110, 32'h3,       1'b1, 32'h8,        1'b0, 3, 1'b1);
    send(3'b101, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'h4,       32'h0,        5'b01111, 32'h4,       1'b1, 32'h0800_0000, 1'b0, 3, 1'b1);
    send(3'b110, 1'b0, 1'b0, 1'b0, 32'h0F,       32'hF0,       32'h0,        5'b01100, 32'hF0,      1'b1, 32'hFF,       1'b0, 3, 1'b1);
    send(3'b000, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h1,       32'h0,        5'b00001, 32'h1,       1'b1, 32'h0,        1'b0, 3, 1'b1);
    send(3'b010, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h1,       32'h0,        5'b00000, 32'h0,       1'b0, 32'h1,        1'b0, 1, 1'b1);
    send(3'b011, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h1,       32'h0,        5'b00000, 32'h0,       1'b0, 32'h0,        1'b0, 1, 1'b1);
    send(3'b010, 1'b0, 1'b1, 1'b0, 32'd5,        32'h0,        32'hFFFF_FFFF, 5'b00000, 32'h0,       1'b0, 32'h0,        1'b0, 1, 1'b1);
    send(3'b011, 1'b0, 1'b1, 1'b0, 32'd5,        32'h0,        32'hFFFF_FFFF, 5'b00000, 32'h0,       1'b0, 32'h1,        1'b0, 1, 1'b1);
    send(3'b111, 1'b0, 1'b0, 1'b0, 32'h0000_F0F0, 32'h0000_FF00, 32'h0,      5'b01010, 32'h0000_FF00, 1'b1, 32'h0000_F000, 1'b0, 3, 1'b1);
    drain();

    // Unsolicited alu_valid in IDLE must leave state and result untouched.
    stray = 1'b1;
    @(posedge clk); #1;
    stray = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("stray_no_out_valid", {31'b0, out_valid}, 32'h0);
    chk("stray_in_ready", {31'b0, in_ready}, 32'h1);
    chk("stray_out_data", out_data, 32'h0000_F000);

    // Writeback backpressure on an XOR result.
    out_ready = 1'b0;
    send(3'b100, 1'b0, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0, 5'b01101, 32'hFF00_FF00, 1'b1, 32'h0FF0_0FF0, 1'b0, 3, 1'b1);
    begin
      int n;
      n = 0;
      while (!out_valid && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
      if (n >= 50) begin
        checks++;
        errors++;
        $display("FAIL stall_wait: out_valid %b", out_valid);
      end
    end
    repeat (5) begin
      @(posedge clk); #1;
    end
    chk("stall_out_valid_held", {31'b0, out_valid}, 32'h1);
    out_ready = 1'b1;
    drain();

    // ALU never answers: error return after the timeout window.
    mute = 1'b1;
    send(3'b000, 1'b0, 1'b0, 1'b0, 32'd1, 32'd1, 32'h0, 5'b00001, 32'd1, 1'b1, 32'h0, 1'b1, 17, 1'b1);
    drain();

    // Reset in WAIT: the in-flight instruction is dropped.
    send(3'b000, 1'b0, 1'b0, 1'b0, 32'd2, 32'd2, 32'h0, 5'b00001, 32'd2, 1'b1, 32'h0, 1'b0, 3, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_alu_en", {31'b0, alu_en}, 32'h0);
    chk("midrst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("midrst_in_ready", {31'b0, in_ready}, 32'h0);
    chk("midrst_alu_op", {27'b0, alu_op}, 32'h0);
    chk("midrst_alu_a", alu_a, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mute = 1'b0;
    @(posedge clk); #1;
    chk("postrst_in_ready", {31'b0, in_ready}, 32'h1);
    repeat (20) begin
      @(posedge clk); #1;
    end
    chk("postrst_no_out_valid", {31'b0, out_valid}, 32'h0);

    // Normal operation resumes after the reset.
    send(3'b000, 1'b1, 1'b0, 1'b0, 32'd100, 32'd1, 32'h0, 5'b00011, 32'd1, 1'b1, 32'd99, 1'b0, 3, 1'b1);
    drain();
    chk("alu_queue_empty", alu_q.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
